// File: rtl/cnn_layer_accel_job_sequencer.sv
// Per-job controller for one cnn_layer_accel_quad: loads config, starts the job, brokers
// fetch rounds with the DMA engine and reports completion or timeout to the scheduler.
module cnn_layer_accel_job_sequencer #(
  parameter int unsigned C_TIMEOUT_CYCLES = 65535,
  parameter int unsigned C_TIMEOUT_W      = 16
) (
  input  logic           clk_if,
  input  logic           rst,
  input  logic           desc_valid,
  output logic           desc_ready,
  input  logic [127:0]   desc_params,
  input  logic [511:0]   desc_cfg,
  output logic [3:0]     config_valid,
  input  logic [3:0]     config_accept,
  output logic [127:0]   config_data,
  output logic           job_start,
  input  logic           job_accept,
  output logic [127:0]   job_parameters,
  input  logic           job_fetch_request,
  output logic           job_fetch_ack,
  output logic           job_fetch_complete,
  output logic           fetch_go,
  input  logic           fetch_done,
  input  logic           job_complete,
  output logic           job_complete_ack,
  output logic           done_valid,
  output logic           done_timeout,
  output logic           busy,
  output logic [15:0]    jobs_done
);

  localparam logic [C_TIMEOUT_W-1:0] TimeoutMax = C_TIMEOUT_W'(C_TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    StIdle, StCfg, StStart, StFetchWait, StFetchRun, StCompWait, StAck
  } state_e;

  state_e                 state_q, state_d;
  logic [1:0]             idx_q, idx_d;
  logic [127:0]           params_q, params_d;
  logic [511:0]           cfg_q, cfg_d;
  logic [C_TIMEOUT_W-1:0] timer_q, timer_d, timer_inc;
  logic                   waiting, timeout, fetch_launch, fetch_finish;

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    params_d     = params_q;
    cfg_d        = cfg_q;
    timeout      = 1'b0;
    fetch_launch = 1'b0;
    fetch_finish = 1'b0;
    timer_inc    = timer_q + 1'b1;
    waiting      = (state_q != StIdle) && (state_q != StAck);

    unique case (state_q)
      StIdle: begin
        if (desc_valid && desc_ready) begin
          params_d = desc_params;
          cfg_d    = desc_cfg;
          idx_d    = 2'd0;
          state_d  = StCfg;
        end
      end
      StCfg: begin
        if (config_accept[idx_q]) begin
          if (idx_q == 2'd3) state_d = StStart;
          else               idx_d   = idx_q + 2'd1;
        end
      end
      StStart: begin
        if (job_accept) state_d = StFetchWait;
      end
      StFetchWait, StCompWait: begin
        // Completion wins over a simultaneous fetch request.
        if (job_complete) begin
          state_d = StAck;
        end else if (job_fetch_request) begin
          state_d      = StFetchRun;
          fetch_launch = 1'b1;
        end
      end
      StFetchRun: begin
        if (fetch_done) begin
          state_d      = StCompWait;
          fetch_finish = 1'b1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (waiting && (timer_inc == TimeoutMax)) begin
      timeout      = 1'b1;
      state_d      = StIdle;
      fetch_launch = 1'b0;
      fetch_finish = 1'b0;
    end

    timer_d = ((state_d != state_q) || !waiting) ? '0 : timer_inc;
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk_if) begin
    if (!rst) begin
      state_q            <= StIdle;
      idx_q              <= 2'd0;
      params_q           <= '0;
      cfg_q              <= '0;
      timer_q            <= '0;
      desc_ready         <= 1'b0;
      busy               <= 1'b0;
      config_valid       <= '0;
      config_data        <= '0;
      job_start          <= 1'b0;
      job_parameters     <= '0;
      job_fetch_ack      <= 1'b0;
      fetch_go           <= 1'b0;
      job_fetch_complete <= 1'b0;
      job_complete_ack   <= 1'b0;
      done_valid         <= 1'b0;
      done_timeout       <= 1'b0;
      jobs_done          <= '0;
    end else begin
      state_q            <= state_d;
      idx_q              <= idx_d;
      params_q           <= params_d;
      cfg_q              <= cfg_d;
      timer_q            <= timer_d;
      desc_ready         <= (state_d == StIdle);
      busy               <= (state_d != StIdle);
      config_valid       <= (state_d == StCfg) ? (4'b0001 << idx_d) : 4'b0000;
      config_data        <= (state_d == StCfg) ? cfg_d[{idx_d, 7'd0} +: 128] : '0;
      job_start          <= (state_d == StStart);
      job_parameters     <= (state_d == StStart) ? params_d : '0;
      job_fetch_ack      <= fetch_launch;
      fetch_go           <= fetch_launch;
      job_fetch_complete <= fetch_finish;
      job_complete_ack   <= (state_d == StAck);
      done_valid         <= (state_d == StAck) || timeout;
      done_timeout       <= timeout;
      if (state_d == StAck) jobs_done <= jobs_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_cnn_layer_accel_job_sequencer.sv
// Bench for cnn_layer_accel_job_sequencer: acts as quad and DMA engine, checks the job protocol
// against expectations derived from the job descriptor and chosen response delays.
module tb_cnn_layer_accel_job_sequencer;

  localparam int unsigned TimeoutCycles = 20;

  logic           clk_if = 1'b0;
  logic           rst;
  logic           desc_valid, desc_ready;
  logic [127:0]   desc_params;
  logic [511:0]   desc_cfg;
  logic [3:0]     config_valid, config_accept;
  logic [127:0]   config_data;
  logic           job_start, job_accept;
  logic [127:0]   job_parameters;
  logic           job_fetch_request, job_fetch_ack, job_fetch_complete;
  logic           fetch_go, fetch_done;
  logic           job_complete, job_complete_ack;
  logic           done_valid, done_timeout, busy;
  logic [15:0]    jobs_done;

  int errors = 0;
  int checks = 0;
  logic [15:0] jobs_exp = 16'd0;
  int cnt_go = 0, cnt_fack = 0, cnt_fcomp = 0, cnt_cack = 0;

  cnn_layer_accel_job_sequencer #(
    .C_TIMEOUT_CYCLES(TimeoutCycles),
    .C_TIMEOUT_W     (16)
  ) dut (
    .clk_if            (clk_if),
    .rst               (rst),
    .desc_valid        (desc_valid),
    .desc_ready        (desc_ready),
    .desc_params       (desc_params),
    .desc_cfg          (desc_cfg),
    .config_valid      (config_valid),
    .config_accept     (config_accept),
    .config_data       (config_data),
    .job_start         (job_start),
    .job_accept        (job_accept),
    .job_parameters    (job_parameters),
    .job_fetch_request (job_fetch_request),
    .job_fetch_ack     (job_fetch_ack),
    .job_fetch_complete(job_fetch_complete),
    .fetch_go          (fetch_go),
    .fetch_done        (fetch_done),
    .job_complete      (job_complete),
    .job_complete_ack  (job_complete_ack),
    .done_valid        (done_valid),
    .done_timeout      (done_timeout),
    .busy              (busy),
    .jobs_done         (jobs_done)
  );

  always #5 clk_if = ~clk_if;

  // Pulse counters sampled mid-cycle, one count per high cycle.
  always @(negedge clk_if) begin
    if (fetch_go)           cnt_go++;
    if (job_fetch_ack)      cnt_fack++;
    if (job_fetch_complete) cnt_fcomp++;
    if (job_complete_ack)   cnt_cack++;
  end

  task automatic tick();
    @(posedge clk_if);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({desc_ready, config_valid, config_data, job_start, job_parameters, job_fetch_ack,
         job_fetch_complete, fetch_go, job_complete_ack, done_valid, done_timeout, busy,
         jobs_done} !== '0) begin
      errors++;
      $display("FAIL %s: outputs not all zero (ready=%b cv=%h start=%b busy=%b jobs=%0d)",
               name, desc_ready, config_valid, job_start, busy, jobs_done);
    end
  endtask

  task automatic setup_job(input string name, input logic [511:0] cfg, input logic [127:0] params,
                           input int s0, input int s1, input int s2, input int s3,
                           input int start_delay);
    int st[4];
    logic bad;
    logic [3:0] got_v;
    logic [127:0] got_d;
    st = '{s0, s1, s2, s3};
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: desc_ready=%b busy=%b, want 1/0", name, desc_ready, busy);
    end
    desc_params = params;
    desc_cfg    = cfg;
    desc_valid  = 1'b1;
    tick();
    desc_valid  = 1'b0;
    desc_params = {$urandom(), $urandom(), $urandom(), $urandom()};
    desc_cfg    = ~cfg;
    for (int k = 0; k < 4; k++) begin
      bad = 1'b0;
      got_v = '0;
      got_d = '0;
      for (int s = 0; s <= st[k]; s++) begin
        config_accept = (s == st[k]) ? (4'(1 << k) | 4'($urandom()))
                                     : (4'($urandom()) & ~4'(1 << k));
        if (!bad && (config_valid !== 4'(1 << k) || config_data !== cfg[128*k +: 128]
                     || busy !== 1'b1 || desc_ready !== 1'b0)) begin
          bad = 1'b1;
          got_v = config_valid;
          got_d = config_data;
        end
        tick();
      end
      config_accept = '0;
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL %s_cfg%0d: valid=%h data=%h, want valid=%h data=%h", name, k, got_v,
                 got_d, 4'(1 << k), cfg[128*k +: 128]);
      end
    end
    bad = 1'b0;
    for (int d = 0; d <= start_delay; d++) begin
      job_accept = (d == start_delay);
      if (job_start !== 1'b1 || job_parameters !== params || config_valid !== 4'b0) bad = 1'b1;
      tick();
    end
    job_accept = 1'b0;
    checks++;
    if (bad || job_start !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: start high for wrong span (now %b), params=%h want %h", name,
               job_start, job_parameters, params);
    end
  endtask

  task automatic fetch_round(input string name, input int gap, input int lat);
    logic bad;
    for (int g = 0; g < gap; g++) tick();
    job_fetch_request = 1'b1;
    tick();
    job_fetch_request = 1'b0;
    checks++;
    if (job_fetch_ack !== 1'b1 || fetch_go !== 1'b1) begin
      errors++;
      $display("FAIL %s_fetch_ack: ack=%b go=%b, want 1/1", name, job_fetch_ack, fetch_go);
    end
    bad = 1'b0;
    for (int i = 0; i < lat; i++) begin
      if (i == lat - 1) fetch_done = 1'b1;
      job_fetch_request = $urandom_range(0, 1) == 1;
      tick();
      if (fetch_go !== 1'b0 || job_fetch_ack !== 1'b0) bad = 1'b1;
      if (i < lat - 1 && job_fetch_complete !== 1'b0) bad = 1'b1;
    end
    fetch_done = 1'b0;
    job_fetch_request = 1'b0;
    checks++;
    if (bad || job_fetch_complete !== 1'b1) begin
      errors++;
      $display("FAIL %s_fetch_complete: complete=%b stray=%b, want 1/0", name,
               job_fetch_complete, bad);
    end
    tick();
  endtask

  task automatic finish_job(input string name, input int comp_lat, input bit collide);
    for (int i = 0; i < comp_lat; i++) tick();
    job_complete = 1'b1;
    job_fetch_request = collide;
    tick();
    job_complete = 1'b0;
    job_fetch_request = 1'b0;
    jobs_exp = jobs_exp + 16'd1;
    checks++;
    if (job_complete_ack !== 1'b1 || done_valid !== 1'b1 || done_timeout !== 1'b0
        || jobs_done !== jobs_exp || fetch_go !== 1'b0) begin
      errors++;
      $display("FAIL %s_ack: ack=%b dv=%b dt=%b go=%b jobs=%0d, want 1/1/0/0 jobs=%0d", name,
               job_complete_ack, done_valid, done_timeout, fetch_go, jobs_done, jobs_exp);
    end
    tick();
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0 || done_valid !== 1'b0 || job_complete_ack !== 1'b0)
    begin
      errors++;
      $display("FAIL %s_idle_after: ready=%b busy=%b dv=%b ack=%b, want 1/0/0/0", name,
               desc_ready, busy, done_valid, job_complete_ack);
    end
  endtask

  task automatic run_job(input string name, input logic [511:0] cfg, input logic [127:0] params,
                         input int s0, input int s1, input int s2, input int s3, input int sd,
                         input int rounds, input int flat, input int clat, input bit collide);
    int go0, fack0, fc0, ca0;
    go0 = cnt_go; fack0 = cnt_fack; fc0 = cnt_fcomp; ca0 = cnt_cack;
    setup_job(name, cfg, params, s0, s1, s2, s3, sd);
    for (int r = 0; r < rounds; r++) fetch_round(name, $urandom_range(0, 2), flat);
    finish_job(name, clat, collide);
    checks++;
    if (cnt_go - go0 != rounds || cnt_fack - fack0 != rounds || cnt_fcomp - fc0 != rounds
        || cnt_cack - ca0 != 1) begin
      errors++;
      $display("FAIL %s_pulses: go=%0d ack=%0d comp=%0d cack=%0d, want %0d/%0d/%0d/1", name,
               cnt_go - go0, cnt_fack - fack0, cnt_fcomp - fc0, cnt_cack - ca0, rounds, rounds,
               rounds);
    end
  endtask

  function automatic logic [511:0] rand_cfg();
    logic [511:0] c;
    for (int k = 0; k < 16; k++) c[32*k +: 32] = $urandom();
    return c;
  endfunction

  function automatic logic [511:0] nominal_cfg();
    logic [511:0] c;
    for (int k = 0; k < 4; k++) c[128*k +: 128] = 128'(8'hA0 + k);
    return c;
  endfunction

  task automatic test_reset();
    rst = 1'b0;
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b1;
    tick();
    checks++;
    if (desc_ready !== 1'b1 || jobs_done !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: ready=%b jobs=%0d, want 1/0", desc_ready, jobs_done);
    end
    jobs_exp = 16'd0;
  endtask

  task automatic test_nominal();
    run_job("nominal", nominal_cfg(), 128'h1234, 0, 0, 0, 0, 0, 1, 5, 10, 1'b0);
  endtask

  task automatic test_backpressure();
    run_job("backpressure", rand_cfg(), 128'hBEEF, 0, 7, 0, 0, 3, 1, 2, 3, 1'b0);
  endtask

  task automatic test_multi_fetch();
    run_job("multi_fetch", rand_cfg(), 128'h5A5A, 0, 0, 0, 0, 0, 3, 4, 2, 1'b0);
  endtask

  task automatic test_collision();
    run_job("collision", rand_cfg(), 128'hC011, 0, 0, 0, 0, 1, 1, 3, 2, 1'b1);
  endtask

  task automatic test_random_jobs();
    for (int j = 0; j < 6; j++) begin
      run_job($sformatf("random%0d", j), rand_cfg(), {$urandom(), $urandom(), $urandom(),
              $urandom()}, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(1, 8), $urandom_range(0, 12), $urandom_range(0, 1) == 1);
    end
  endtask

  task automatic test_timeout();
    int n;
    setup_job("timeout", rand_cfg(), 128'h7, 0, 0, 0, 0, 0);
    job_fetch_request = 1'b1;
    tick();
    job_fetch_request = 1'b0;
    n = 0;
    while (done_valid !== 1'b1 && n < 2 * TimeoutCycles) begin
      tick();
      n++;
    end
    checks++;
    if (n != TimeoutCycles || done_timeout !== 1'b1 || jobs_done !== jobs_exp
        || desc_ready !== 1'b1 || busy !== 1'b0 || fetch_go !== 1'b0 || job_complete_ack !== 1'b0)
    begin
      errors++;
      $display("FAIL timeout: after %0d cycles dv=%b dt=%b ready=%b jobs=%0d, want %0d/1/1/1 jobs=%0d",
               n, done_valid, done_timeout, desc_ready, jobs_done, TimeoutCycles, jobs_exp);
    end
    tick();
    checks++;
    if (done_valid !== 1'b0 || done_timeout !== 1'b0 || desc_ready !== 1'b1) begin
      errors++;
      $display("FAIL timeout_pulse: dv=%b dt=%b ready=%b, want 0/0/1", done_valid, done_timeout,
               desc_ready);
    end
  endtask

  task automatic test_mid_job_reset();
    setup_job("midreset", rand_cfg(), 128'h99, 0, 0, 0, 0, 0);
    job_fetch_request = 1'b1;
    tick();
    job_fetch_request = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_all_zero("midreset");
    rst = 1'b1;
    jobs_exp = 16'd0;
    tick();
    checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL midreset_release: ready=%b busy=%b, want 1/0", desc_ready, busy);
    end
    run_job("after_reset", rand_cfg(), 128'hAA, 1, 0, 2, 0, 1, 2, 3, 4, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    desc_valid = 1'b0;
    desc_params = '0;
    desc_cfg = '0;
    config_accept = '0;
    job_accept = 1'b0;
    job_fetch_request = 1'b0;
    fetch_done = 1'b0;
    job_complete = 1'b0;
    test_reset();
    test_nominal();
    test_backpressure();
    test_multi_fetch();
    test_collision();
    test_random_jobs();
    test_timeout();
    test_mid_job_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cnn_layer_accel_job_sequencer.md
# cnn_layer_accel_job_sequencer

Per-job controller in front of one `cnn_layer_accel_quad`, in the `clk_if` domain. Accepts a job descriptor holding 128-bit job parameters and four 128-bit config words. Walks the quad through its full job protocol: config load, start/accept, fetch request/ack/complete (repeatable), then complete/ack. Reports per-job completion or timeout to the host-side scheduler.

## Interface
Parameters:
- `C_TIMEOUT_CYCLES`, default 65535: maximum cycles spent in any wait state before the job is aborted.
- `C_TIMEOUT_W`, default 16: width of the timeout counter; must hold `C_TIMEOUT_CYCLES`.

Ports:
- `clk_if` in 1: interface clock; the only clock.
- `rst` in 1: synchronous, active-low reset.
- `desc_valid` in 1 / `desc_ready` out 1: descriptor handshake.
- `desc_params` in 128: job parameters for the quad.
- `desc_cfg` in 512: config words; word k is `[128k+127:128k]`.
- `config_valid` out 4 / `config_accept` in 4 / `config_data` out 128: one-hot config write to the quad.
- `job_start` out 1 / `job_accept` in 1 / `job_parameters` out 128: job start to the quad.
- `job_fetch_request` in 1 / `job_fetch_ack` out 1 / `job_fetch_complete` out 1: fetch handshake with the quad.
- `fetch_go` out 1 / `fetch_done` in 1: pulse to and completion from the external fetch (DMA) engine.
- `job_complete` in 1 / `job_complete_ack` out 1: job completion handshake with the quad.
- `done_valid` out 1, `done_timeout` out 1: one-cycle completion report; `done_timeout` is qualified by `done_valid`.
- `busy` out 1: high in any state except IDLE.
- `jobs_done` out 16: count of jobs that completed normally; wraps 0xFFFF→0.

## Operation
- All outputs are registered.
- Reset (`rst`=0 at a clock edge), including mid-job: state→IDLE, all outputs 0, `jobs_done`=0, latched descriptor cleared. The quad is reset by its own `rst`.

State machine:
- **IDLE**: `desc_ready`=1. On `desc_valid&&desc_ready`, latch `desc_params`/`desc_cfg`, set idx=0, go to CFG.
- **CFG**: `config_valid`=1<<idx, `config_data`=cfg[idx].
  - On `config_accept[idx]`: if idx<3, idx+1 and the next word is presented the next cycle; if idx=3, go to START.
  - `config_accept` bits other than idx are ignored.
- **START**: `job_start`=1, `job_parameters`=latched params. Both are held until `job_accept`=1 is sampled, then go to FETCH_WAIT.
- **FETCH_WAIT** and **COMP_WAIT**:
  - `job_complete` → ACK. `job_complete` has priority if asserted in the same cycle as `job_fetch_request`.
  - Otherwise `job_fetch_request` → pulse `job_fetch_ack` and `fetch_go` (one cycle each), go to FETCH_RUN.
- **FETCH_RUN**: on `fetch_done`, pulse `job_fetch_complete` one cycle, go to COMP_WAIT.
  - `job_fetch_request` in this state is ignored.
  - Fetch rounds per job are unlimited.
- **ACK**: one cycle. `job_complete_ack`=1, `done_valid`=1, `done_timeout`=0, `jobs_done`+1, then go to IDLE.

Timeout:
- The counter clears on every state change and increments each cycle in CFG, START, FETCH_WAIT, FETCH_RUN and COMP_WAIT.
- When the count equals `C_TIMEOUT_CYCLES`: drop all quad-side outputs, pulse `done_valid`=1 with `done_timeout`=1, go to IDLE. `jobs_done` is unchanged.

## Timing
- Descriptor accept edge → `config_valid` high on the next cycle.
- Each config beat takes at least 1 cycle; with `config_accept` tied high, four beats take 4 cycles.
- Final `config_accept` → `job_start` high on the next cycle.
- `job_accept` sampled → `job_start` low on the next cycle.
- `job_fetch_request` → `job_fetch_ack`/`fetch_go` high exactly 1 cycle, starting the next cycle.
- `fetch_done` → `job_fetch_complete` 1-cycle pulse on the next cycle.
- `job_complete` → `job_complete_ack` and `done_valid` 1-cycle pulse on the next cycle. `desc_ready`=1 the cycle after that.
- No back-to-back overlap: a new descriptor is accepted no earlier than 1 cycle after ACK.
- `busy` falls in the same cycle `desc_ready` rises.

## Test plan
- Nominal job: cfg words 0x…A0–0x…A3, params 0x1234, accepts tied high, one fetch round, `fetch_done` 5 cycles after `fetch_go`, `job_complete` 10 cycles later. Required: `config_valid` sequence 1,2,4,8 with matching data; one `job_start`; one ack pulse each for fetch and complete; `done_valid`=1, `done_timeout`=0, `jobs_done`=1.
- Backpressure: `config_accept[1]` held low 7 cycles, `job_accept` delayed 3 cycles. Required: `config_data`=word1 held stable for 8 cycles; `job_start` high exactly 4 cycles.
- Three fetch rounds before `job_complete`. Required: 3 `fetch_go` pulses, 3 `job_fetch_complete` pulses, then a single `job_complete_ack`.
- `job_complete` and `job_fetch_request` asserted in the same cycle in COMP_WAIT. Required: ACK taken, no `fetch_go`.
- `C_TIMEOUT_CYCLES`=20, `fetch_done` never arrives. Required: 20 cycles after entering FETCH_RUN, `done_valid`=`done_timeout`=1, IDLE, `jobs_done` unchanged.
- `rst`=0 for 1 cycle during FETCH_RUN. Required: all outputs 0 the next cycle, `jobs_done`=0, `desc_ready`=1 once `rst`=1.
